fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, tracks the PC,
// and feeds the IF/ID register through a one-entry skid buffer under decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        req_r, req_s;
  logic        ifid_valid_r, ifid_valid_s;
  logic [31:0] ifid_pc_r, ifid_pc_s;
  logic [31:0] ifid_instr_r, ifid_instr_s;
  logic        skid_valid_r, skid_valid_s;
  logic [31:0] skid_pc_r, skid_pc_s;
  logic [31:0] skid_instr_r, skid_instr_s;
  logic        hs_s;
  logic [31:0] br_pc_s;

  // Request only exists in FETCH, so a handshake needs nothing more than ready.
  assign hs_s    = req_r & imem_ready_i;
  assign br_pc_s = {br_target_i[31:2], 2'b00};

  // Next-state, PC, IF/ID and skid buffer computation.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    ifid_valid_s = ifid_valid_r;
    ifid_pc_s    = ifid_pc_r;
    ifid_instr_s = ifid_instr_r;
    skid_valid_s = skid_valid_r;
    skid_pc_s    = skid_pc_r;
    skid_instr_s = skid_instr_r;

    case (state_r)
      ST_WAIT: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (br_taken_i) begin
          // Redirect wins; any word returning this cycle is dropped.
          pc_s         = br_pc_s;
          ifid_valid_s = 1'b0;
          skid_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else if (hs_s) begin
          pc_s = pc_r + 32'd4;
          if (stall_i) begin
            skid_valid_s = 1'b1;
            skid_pc_s    = pc_r;
            skid_instr_s = imem_rdata_i;
            state_s      = ST_HOLD;
          end else begin
            ifid_valid_s = 1'b1;
            ifid_pc_s    = pc_r;
            ifid_instr_s = imem_rdata_i;
          end
        end else if (!stall_i) begin
          ifid_valid_s = 1'b0;
        end else begin
          ifid_valid_s = ifid_valid_r;
        end
      end
      ST_HOLD: begin
        if (br_taken_i) begin
          pc_s         = br_pc_s;
          ifid_valid_s = 1'b0;
          skid_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else if (!stall_i) begin
          ifid_valid_s = 1'b1;
          ifid_pc_s    = skid_pc_r;
          ifid_instr_s = skid_instr_r;
          skid_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean post-reset state.
        state_s      = ST_WAIT;
        ifid_valid_s = 1'b0;
        skid_valid_s = 1'b0;
      end
    endcase

    req_s = (state_s == ST_FETCH);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_WAIT;
      pc_r         <= RESET_PC;
      req_r        <= 1'b0;
      ifid_valid_r <= 1'b0;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_instr_r <= 32'h0000_0000;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_r        <= req_s;
      ifid_valid_r <= ifid_valid_s;
      ifid_pc_r    <= ifid_pc_s;
      ifid_instr_r <= ifid_instr_s;
      skid_valid_r <= skid_valid_s;
      skid_pc_r    <= skid_pc_s;
      skid_instr_r <= skid_instr_s;
    end
  end

  assign imem_req_o   = req_r;
  assign imem_addr_o  = pc_r;
  assign ifid_valid_o = ifid_valid_r;
  assign ifid_pc_o    = ifid_pc_r;
  assign ifid_instr_o = ifid_instr_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ready_i(imem_ready_i),
    .imem_rdata_i(imem_rdata_i),
    .ifid_valid_o(ifid_valid_o),
    .ifid_pc_o   (ifid_pc_o),
    .ifid_instr_o(ifid_instr_o)
  );

  always #5 clk = ~clk;

  // Reference model: a started flag, a PC, a queue of parked words, and IF/ID contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        started_m = 1'b0;
  logic [31:0] pc_m = RST_PC;
  ent_t        skid_q[$];
  logic        ifv_m = 1'b0;
  logic [31:0] ifpc_m = 32'h0;
  logic [31:0] ifinstr_m = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (!rst_n) begin
      started_m = 1'b0;
      pc_m      = RST_PC;
      skid_q.delete();
      ifv_m     = 1'b0;
      ifpc_m    = 32'h0;
      ifinstr_m = 32'h0;
    end else if (!started_m) begin
      started_m = 1'b1;
    end else if (br_taken_i) begin
      pc_m = br_target_i & 32'hFFFF_FFFC;
      ifv_m = 1'b0;
      skid_q.delete();
    end else if (skid_q.size() != 0) begin
      if (!stall_i) begin
        e = skid_q.pop_front();
        ifv_m = 1'b1;
        ifpc_m = e.pc;
        ifinstr_m = e.instr;
      end
    end else if (imem_ready_i) begin
      if (stall_i) begin
        e.pc = pc_m;
        e.instr = imem_rdata_i;
        skid_q.push_back(e);
      end else begin
        ifv_m = 1'b1;
        ifpc_m = pc_m;
        ifinstr_m = imem_rdata_i;
      end
      pc_m = pc_m + 32'd4;
    end else if (!stall_i) begin
      ifv_m = 1'b0;
    end
  endtask

  task automatic step();
    logic req_exp;
    @(posedge clk);
    model_edge();
    #1;
    req_exp = started_m && (skid_q.size() == 0);
    chk("req",   {31'd0, imem_req_o},   {31'd0, req_exp});
    chk("addr",  imem_addr_o,           pc_m);
    chk("valid", {31'd0, ifid_valid_o}, {31'd0, ifv_m});
    chk("ifpc",  ifid_pc_o,             ifpc_m);
    chk("instr", ifid_instr_o,          ifinstr_m);
  endtask

  logic [31:0] saved_pc;
  logic [31:0] saved_addr;

  initial begin
    // Reset for two edges, then full-throughput streaming.
    step();
    step();
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, RST_PC);
    rst_n = 1'b1;
    imem_ready_i = 1'b1;
    imem_rdata_i = 32'h1111_0000;
    step();
    chk("wait_to_fetch_req", {31'd0, imem_req_o}, 32'd1);
    for (int i = 0; i < 20 && imem_addr_o != 32'h10; i++) begin
      imem_rdata_i = 32'h1111_0000 + imem_addr_o;
      step();
    end
    chk("reach_0x10", imem_addr_o, 32'h0000_0010);
    chk("stream_valid", {31'd0, ifid_valid_o}, 32'd1);
    chk("stream_ifpc", ifid_pc_o, 32'h0000_000C);

    // Handshake at 0x10 under stall, stall held 3 cycles, then release.
    stall_i = 1'b1;
    imem_rdata_i = 32'hCAFE_0010;
    saved_pc = ifid_pc_o;
    step();
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    imem_rdata_i = 32'hBAD0_BAD0;
    step();
    step();
    chk("hold_ifpc", ifid_pc_o, saved_pc);
    stall_i = 1'b0;
    imem_ready_i = 1'b0;
    step();
    chk("release_ifpc", ifid_pc_o, 32'h0000_0010);
    chk("release_instr", ifid_instr_o, 32'hCAFE_0010);
    chk("resume_addr", imem_addr_o, 32'h0000_0014);

    // Redirect during a stalled handshake: word dropped, target aligned.
    br_taken_i = 1'b1;
    br_target_i = 32'h0000_0103;
    stall_i = 1'b1;
    imem_ready_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    step();
    chk("br_addr", imem_addr_o, 32'h0000_0100);
    chk("br_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("br_req", {31'd0, imem_req_o}, 32'd1);
    br_taken_i = 1'b0;
    stall_i = 1'b0;
    imem_ready_i = 1'b0;
    step();
    chk("br_no_old_word", ifid_instr_o, 32'hCAFE_0010);

    // PC wrap at the top of the address space.
    br_taken_i = 1'b1;
    br_target_i = 32'hFFFF_FFFE;
    step();
    br_taken_i = 1'b0;
    imem_ready_i = 1'b1;
    imem_rdata_i = 32'h5A5A_A5A5;
    step();
    chk("wrap_addr", imem_addr_o, 32'h0000_0000);
    chk("wrap_ifpc", ifid_pc_o, 32'hFFFF_FFFC);

    // Memory not ready for two cycles, then reset while in HOLD.
    imem_ready_i = 1'b0;
    saved_addr = imem_addr_o;
    step();
    chk("nready1_valid", {31'd0, ifid_valid_o}, 32'd0);
    step();
    chk("nready2_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("nready_addr", imem_addr_o, saved_addr);
    imem_ready_i = 1'b1;
    stall_i = 1'b1;
    imem_rdata_i = 32'h7777_7777;
    step();
    rst_n = 1'b0;
    step();
    chk("hold_rst_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("hold_rst_instr", ifid_instr_o, 32'd0);
    chk("hold_rst_addr", imem_addr_o, RST_PC);
    rst_n = 1'b1;
    stall_i = 1'b0;
    step();

    // Random traffic with occasional resets and redirects.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(63) != 0);
      stall_i      = ($urandom_range(2) == 0);
      imem_ready_i = ($urandom_range(3) != 0);
      imem_rdata_i = $urandom;
      br_taken_i   = ($urandom_range(7) == 0);
      br_target_i  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F))
                                              : $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
